datamemory_lsu: RTL and testbench



---
 rtl/datamemory_lsu.sv | 194 +++++++++++++++++++
 tb/tb_datamemory_lsu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/datamemory_lsu.sv
// Load/store unit with sub-word access, sign/zero extension and configurable load latency.
// Optional macro DM_MISALIGN_ERR_EN: reject misaligned H/W accesses instead of force-aligning them.
module datamemory_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic [DATA_W-1:0]     rd,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  err,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request is taken on a rising edge only when ready=1 and exactly
  // one of MemRead/MemWrite is high; rvalid and err are single-cycle pulses.

  localparam int DEPTH = 1 << (DM_ADDRESS - 2);
  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  if (DATA_W != 32) begin : g_bad_width
    $error("datamemory_lsu: DATA_W must be 32");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_bad_lat
    $error("datamemory_lsu: LOAD_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_cnt;
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_word;
  logic [1:0]              r_lane;
  logic [2:0]              r_f3;
  logic                    r_bad;
  logic [DATA_W-1:0]       r_rd;
  logic                    r_err;

  logic [DM_ADDRESS-3:0]   w_idx;
  logic [1:0]              w_lane;
  logic                    w_mis_bad;
  logic                    w_f3_load_ok;
  logic                    w_f3_store_ok;
  logic                    w_load_bad;
  logic                    w_store_bad;
  logic                    w_ready;
  logic                    w_ld_acc;
  logic                    w_st_acc;
  logic                    w_dual;
  logic                    w_we;
  logic [3:0]              w_be;
  logic [DATA_W-1:0]       w_wdata;
  logic                    w_fin;
  logic                    w_fin_bad;
  logic [DATA_W-1:0]       w_fin_data;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [2:0] f3, input logic bad);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    extract = '0;
    if (!bad) begin
      case (f3[1:0])
        2'b00:   extract = {{24{~f3[2] & sh[7]}}, sh[7:0]};
        2'b01:   extract = {{16{~f3[2] & sh[15]}}, sh[15:0]};
        default: extract = word;
      endcase
    end
  endfunction

  assign w_idx         = a[DM_ADDRESS-1:2];
  assign w_f3_load_ok  = (Funct3[1:0] != 2'b11) && !(Funct3[2] && Funct3[1]);
  assign w_f3_store_ok = !Funct3[2] && (Funct3[1:0] != 2'b11);

`ifdef DM_MISALIGN_ERR_EN
  assign w_lane    = a[1:0];
  assign w_mis_bad = ((Funct3[1:0] == 2'b01) && a[0]) ||
                     ((Funct3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
  // Misaligned H/W accesses silently drop the offending low address bits.
  assign w_lane    = (Funct3[1:0] == 2'b01) ? {a[1], 1'b0} :
                     (Funct3[1:0] == 2'b10) ? 2'b00 : a[1:0];
  assign w_mis_bad = 1'b0;
`endif

  assign w_load_bad  = !w_f3_load_ok || w_mis_bad;
  assign w_store_bad = !w_f3_store_ok || w_mis_bad;

  assign w_ready  = (r_state != S_WAIT);
  assign w_ld_acc = w_ready && MemRead && !MemWrite;
  assign w_st_acc = w_ready && MemWrite && !MemRead;
  assign w_dual   = w_ready && MemRead && MemWrite;
  assign w_we     = w_st_acc && !w_store_bad;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = wd;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{wd[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wd[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // With single-cycle latency the result is formed straight from the array at
  // acceptance; otherwise from the word captured at acceptance.
  always_comb begin
    if (LOAD_LAT == 1) begin
      w_fin      = w_ld_acc;
      w_fin_bad  = w_load_bad;
      w_fin_data = extract(r_mem[w_idx], w_lane, Funct3, w_load_bad);
    end else begin
      w_fin      = (r_state == S_WAIT) && (r_cnt == 3'd1);
      w_fin_bad  = r_bad;
      w_fin_data = extract(r_word, r_lane, r_f3, r_bad);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_ld_acc) w_state_nxt = (LOAD_LAT == 1) ? S_RESP : S_WAIT;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: if (r_cnt == 3'd1) w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 3'd0;
      r_word <= '0;
      r_lane <= 2'b00;
      r_f3   <= 3'b000;
      r_bad  <= 1'b0;
      r_rd   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_ld_acc) begin
        r_cnt  <= LAT_M1;
        r_word <= r_mem[w_idx];
        r_lane <= w_lane;
        r_f3   <= Funct3;
        r_bad  <= w_load_bad;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_fin) r_rd <= w_fin_data;
      r_err <= w_dual || (w_st_acc && w_store_bad) || (w_fin && w_fin_bad);
    end
  end

  assign rd          = r_rd;
  assign rvalid      = (r_state == S_RESP);
  assign ready       = w_ready;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_datamemory_lsu.sv
// Directed bench for datamemory_lsu: three instances at LOAD_LAT 1, 3 and 4.
module tb_datamemory_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n, mem_read, mem_write;
  logic [8:0]  a_i  [3];
  logic [31:0] wd_i [3];
  logic [2:0]  f3_i [3];
  logic [31:0] rd_o [3];
  logic [1:0]  dbg_o[3];
  logic [2:0]  rvalid_o, ready_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .a(a_i[0]), .wd(wd_i[0]), .Funct3(f3_i[0]), .rd(rd_o[0]), .rvalid(rvalid_o[0]),
    .ready(ready_o[0]), .err(err_o[0]), .o_dbg_state(dbg_o[0]));

  datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LOAD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .a(a_i[1]), .wd(wd_i[1]), .Funct3(f3_i[1]), .rd(rd_o[1]), .rvalid(rvalid_o[1]),
    .ready(ready_o[1]), .err(err_o[1]), .o_dbg_state(dbg_o[1]));

  datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LOAD_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n[2]), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
    .a(a_i[2]), .wd(wd_i[2]), .Funct3(f3_i[2]), .rd(rd_o[2]), .rvalid(rvalid_o[2]),
    .ready(ready_o[2]), .err(err_o[2]), .o_dbg_state(dbg_o[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int k, input logic [8:0] addr, input logic [31:0] data,
                          input logic [2:0] f3);
    a_i[k] = addr; wd_i[k] = data; f3_i[k] = f3;
    mem_write[k] = 1'b1;
    step();
    mem_write[k] = 1'b0;
  endtask

  task automatic do_load(input int k, input int lat, input logic [8:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    a_i[k] = addr; f3_i[k] = f3;
    mem_read[k] = 1'b1;
    step();
    mem_read[k] = 1'b0;
    n = 1;
    while (!rvalid_o[k] && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, " latency"}, n, lat);
    check_eq({tag, " rd"}, rd_o[k], exp_rd);
    check_eq({tag, " err"}, {31'd0, err_o[k]}, {31'd0, exp_err});
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 3'b000; mem_read = 3'b000; mem_write = 3'b000;
    for (int k = 0; k < 3; k++) begin
      a_i[k] = '0; wd_i[k] = '0; f3_i[k] = '0;
    end
    repeat (2) step();
    rst_n = 3'b111;
    step();

    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("reset ready %0d", k), {31'd0, ready_o[k]}, 32'd1);
      check_eq($sformatf("reset rvalid %0d", k), {31'd0, rvalid_o[k]}, 32'd0);
      check_eq($sformatf("reset err %0d", k), {31'd0, err_o[k]}, 32'd0);
      check_eq($sformatf("reset rd %0d", k), rd_o[k], 32'd0);
    end

    // LOAD_LAT=1: word/byte/halfword traffic
    do_store(0, 9'h010, 32'h80F0_1234, 3'b010);
    check_eq("sw err", {31'd0, err_o[0]}, 32'd0);
    do_load(0, 1, 9'h010, 3'b010, 32'h80F0_1234, 1'b0, "lw 010");
    do_store(0, 9'h013, 32'h0000_00AA, 3'b000);
    do_load(0, 1, 9'h013, 3'b000, 32'hFFFF_FFAA, 1'b0, "lb 013");
    do_load(0, 1, 9'h013, 3'b100, 32'h0000_00AA, 1'b0, "lbu 013");
    do_load(0, 1, 9'h010, 3'b010, 32'hAAF0_1234, 1'b0, "lw after sb");
    do_load(0, 1, 9'h010, 3'b001, 32'h0000_1234, 1'b0, "lh 010");
    do_load(0, 1, 9'h012, 3'b101, 32'h0000_AAF0, 1'b0, "lhu 012");
    do_load(0, 1, 9'h012, 3'b001, 32'hFFFF_AAF0, 1'b0, "lh 012");
    do_store(0, 9'h014, 32'h1122_3344, 3'b010);
    do_store(0, 9'h016, 32'h0000_BEEF, 3'b001);
    do_load(0, 1, 9'h014, 3'b010, 32'hBEEF_3344, 1'b0, "lw after sh");

    // back-to-back loads
    a_i[0] = 9'h010; f3_i[0] = 3'b010; mem_read[0] = 1'b1;
    step();
    check_eq("b2b1 rvalid", {31'd0, rvalid_o[0]}, 32'd1);
    check_eq("b2b1 ready", {31'd0, ready_o[0]}, 32'd1);
    check_eq("b2b1 rd", rd_o[0], 32'hAAF0_1234);
    a_i[0] = 9'h014;
    step();
    mem_read[0] = 1'b0;
    check_eq("b2b2 rvalid", {31'd0, rvalid_o[0]}, 32'd1);
    check_eq("b2b2 rd", rd_o[0], 32'hBEEF_3344);
    step();
    check_eq("b2b end rvalid", {31'd0, rvalid_o[0]}, 32'd0);
    check_eq("rd hold", rd_o[0], 32'hBEEF_3344);

    // illegal stores
    do_store(0, 9'h010, 32'h0, 3'b011);
    check_eq("f3 011 store err", {31'd0, err_o[0]}, 32'd1);
    step();
    check_eq("err pulse end", {31'd0, err_o[0]}, 32'd0);
    do_store(0, 9'h010, 32'h0, 3'b100);
    check_eq("sbu store err", {31'd0, err_o[0]}, 32'd1);
    step();

    // dual request
    a_i[0] = 9'h010; wd_i[0] = 32'h0; f3_i[0] = 3'b010;
    mem_read[0] = 1'b1; mem_write[0] = 1'b1;
    step();
    mem_read[0] = 1'b0; mem_write[0] = 1'b0;
    check_eq("dual err", {31'd0, err_o[0]}, 32'd1);
    check_eq("dual rvalid", {31'd0, rvalid_o[0]}, 32'd0);
    step();
    check_eq("dual rvalid later", {31'd0, rvalid_o[0]}, 32'd0);
    check_eq("dual err end", {31'd0, err_o[0]}, 32'd0);
    do_load(0, 1, 9'h010, 3'b010, 32'hAAF0_1234, 1'b0, "lw after rejects");
    do_load(0, 1, 9'h010, 3'b011, 32'h0, 1'b1, "illegal load");

    // misaligned accesses
`ifdef DM_MISALIGN_ERR_EN
    do_load(0, 1, 9'h012, 3'b010, 32'h0, 1'b1, "misaligned lw");
    do_store(0, 9'h011, 32'h0000_5555, 3'b001);
    check_eq("misaligned sh err", {31'd0, err_o[0]}, 32'd1);
    step();
    do_load(0, 1, 9'h010, 3'b010, 32'hAAF0_1234, 1'b0, "lw after misaligned sh");
`else
    do_load(0, 1, 9'h012, 3'b010, 32'hAAF0_1234, 1'b0, "misaligned lw");
    do_store(0, 9'h011, 32'h0000_5555, 3'b001);
    check_eq("misaligned sh err", {31'd0, err_o[0]}, 32'd0);
    step();
    do_load(0, 1, 9'h010, 3'b010, 32'hAAF0_5555, 1'b0, "lw after misaligned sh");
`endif

    // LOAD_LAT=3 with a store attempted while busy
    do_store(1, 9'h010, 32'h80F0_1234, 3'b010);
    a_i[1] = 9'h012; f3_i[1] = 3'b001; mem_read[1] = 1'b1;
    step();
    mem_read[1] = 1'b0;
    check_eq("lat3 c1 ready", {31'd0, ready_o[1]}, 32'd0);
    check_eq("lat3 c1 rvalid", {31'd0, rvalid_o[1]}, 32'd0);
    a_i[1] = 9'h010; wd_i[1] = 32'h0; f3_i[1] = 3'b010; mem_write[1] = 1'b1;
    step();
    mem_write[1] = 1'b0;
    check_eq("lat3 c2 ready", {31'd0, ready_o[1]}, 32'd0);
    check_eq("lat3 c2 rvalid", {31'd0, rvalid_o[1]}, 32'd0);
    check_eq("lat3 busy store err", {31'd0, err_o[1]}, 32'd0);
    step();
    check_eq("lat3 c3 rvalid", {31'd0, rvalid_o[1]}, 32'd1);
    check_eq("lat3 c3 ready", {31'd0, ready_o[1]}, 32'd1);
    check_eq("lat3 lh rd", rd_o[1], 32'hFFFF_80F0);
    step();
    check_eq("lat3 rvalid end", {31'd0, rvalid_o[1]}, 32'd0);
    do_load(1, 3, 9'h010, 3'b010, 32'h80F0_1234, 1'b0, "lat3 lw");

    // LOAD_LAT=4 with reset during a pending load
    do_store(2, 9'h020, 32'hCAFE_F00D, 3'b010);
    a_i[2] = 9'h020; f3_i[2] = 3'b010; mem_read[2] = 1'b1;
    step();
    mem_read[2] = 1'b0;
    step();
    step();
    rst_n[2] = 1'b0;
    #1;
    check_eq("lat4 rst ready", {31'd0, ready_o[2]}, 32'd1);
    check_eq("lat4 rst rvalid", {31'd0, rvalid_o[2]}, 32'd0);
    step();
    step();
    rst_n[2] = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      if (rvalid_o[2]) seen++;
    end
    check_eq("lat4 dropped rvalid", seen, 0);
    check_eq("lat4 ready after rst", {31'd0, ready_o[2]}, 32'd1);
    check_eq("lat4 rd after rst", rd_o[2], 32'd0);
    do_load(2, 4, 9'h020, 3'b010, 32'hCAFE_F00D, 1'b0, "lat4 lw");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
